// File: rtl/motion_diff_detect.sv
`default_nettype none
// ============================================================================
//  Module   : motion_diff_detect
//  Purpose  : Frame-difference motion detector. Each pixel gets a registered
//             absolute difference and a strict threshold compare, producing a
//             binary mask with the sync signals delayed to match (2 clk).
//             Per-frame statistics (motion pixel count, motion flag and an
//             optional bounding box) are published once each frame completes.
//  Ports    : clk, rst_n                     - pixel clock, async active-low reset
//             data_cur, data_next, threshold - pixel pair and difference threshold
//             per_frame_vsync/href/clken     - input frame/line/pixel valid
//             post_frame_vsync/href/clken    - sync signals delayed by 2 clk
//             post_img_bit                   - mask, all-ones = motion
//             motion_cnt, motion_flag        - last completed frame statistics
//             frame_done                     - 1-cycle pulse on statistics update
//             bbox_xmin/xmax/ymin/ymax       - motion bounding box
//  Options  : MOTION_BBOX_EN - build the bounding-box trackers; when undefined
//             the bbox outputs are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module motion_diff_detect #(
    parameter int DATA_W     = 8,
    parameter int X_W        = 11,
    parameter int Y_W        = 11,
    parameter int CNT_W      = 21,
    parameter int MIN_PIXELS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_cur,
    input  logic [DATA_W-1:0] data_next,
    input  logic [DATA_W-1:0] threshold,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img_bit,
    output logic [CNT_W-1:0]  motion_cnt,
    output logic              motion_flag,
    output logic              frame_done,
    output logic [X_W-1:0]    bbox_xmin,
    output logic [X_W-1:0]    bbox_xmax,
    output logic [Y_W-1:0]    bbox_ymin,
    output logic [Y_W-1:0]    bbox_ymax
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pixel pipeline: stage 1 = |diff| + threshold capture, stage 2 = mask
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] diff_d;
    logic [DATA_W-1:0] diff_q;
    logic [DATA_W-1:0] thr_q;
    logic [2:0]        sync1_q;   // {vsync, href, clken}
    logic [2:0]        sync2_q;
    logic              mask_q;

    // Subtract the smaller from the larger so the result never wraps.
    assign diff_d = (data_next >= data_cur) ? (data_next - data_cur)
                                            : (data_cur - data_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q  <= '0;
            thr_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            mask_q  <= 1'b0;
        end else begin
            diff_q  <= diff_d;
            thr_q   <= threshold;
            sync1_q <= {per_frame_vsync, per_frame_href, per_frame_clken};
            sync2_q <= sync1_q;
            mask_q  <= (diff_q > thr_q);
        end
    end

    assign post_frame_vsync = sync2_q[2];
    assign post_frame_href  = sync2_q[1];
    assign post_frame_clken = sync2_q[0];
    assign post_img_bit     = {DATA_W{mask_q}};

    // ------------------------------------------------------------------
    // Frame control
    // ------------------------------------------------------------------
    logic   vs_prev_q;
    logic   armed_q;      // set once input vsync has been seen low after reset
    logic   pend_q, pend_d;
    state_t state_q, state_d;
    logic   vs_rise, vs_fall, hit;
    logic   clr, acc_en, publish;

    // A frame already running when reset is released must not be counted:
    // its post vsync rises out of the reset-cleared pipeline, so edges are
    // ignored until the input vsync has been observed low at least once.
    assign vs_rise = post_frame_vsync & ~vs_prev_q & armed_q;
    assign vs_fall = ~post_frame_vsync & vs_prev_q;
    assign hit     = post_frame_vsync & post_frame_href & post_frame_clken & mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= 1'b0;
            armed_q   <= 1'b0;
            pend_q    <= 1'b0;
            state_q   <= S_IDLE;
        end else begin
            vs_prev_q <= post_frame_vsync;
            armed_q   <= armed_q | ~per_frame_vsync;
            pend_q    <= pend_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        clr     = 1'b0;
        acc_en  = 1'b0;
        publish = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (vs_rise || pend_q) begin
                    clr     = 1'b1;
                    pend_d  = 1'b0;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                acc_en = 1'b1;
                if (vs_fall) begin
                    state_d = S_PUBLISH;
                end
            end
            S_PUBLISH: begin
                publish = 1'b1;
                // A new frame starting right now is remembered for IDLE.
                if (vs_rise) begin
                    pend_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Motion pixel count and published statistics
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             flag_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (clr) begin
                acc_q <= {{(CNT_W-1){1'b0}}, hit};
            end else if (acc_en && hit && (acc_q != {CNT_W{1'b1}})) begin
                acc_q <= acc_q + 1'b1;
            end
            if (publish) begin
                cnt_q  <= acc_q;
                flag_q <= (acc_q >= CNT_W'(MIN_PIXELS));
            end
            done_q <= publish;
        end
    end

    assign motion_cnt  = cnt_q;
    assign motion_flag = flag_q;
    assign frame_done  = done_q;

`ifdef MOTION_BBOX_EN
    // ------------------------------------------------------------------
    // Coordinates of the stage-2 pixel and bounding-box trackers
    // ------------------------------------------------------------------
    logic [X_W-1:0] x_q, xmin_q, xmax_q, bxmin_q, bxmax_q;
    logic [Y_W-1:0] y_q, ymin_q, ymax_q, bymin_q, bymax_q;
    logic           href_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            href_prev_q <= 1'b0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            bxmin_q     <= '0;
            bxmax_q     <= '0;
            bymin_q     <= '0;
            bymax_q     <= '0;
        end else begin
            href_prev_q <= post_frame_href;

            if (!post_frame_href) begin
                x_q <= '0;
            end else if (post_frame_clken && (x_q != {X_W{1'b1}})) begin
                x_q <= x_q + 1'b1;
            end

            if (!post_frame_vsync) begin
                y_q <= '0;
            end else if (href_prev_q && !post_frame_href && (y_q != {Y_W{1'b1}})) begin
                y_q <= y_q + 1'b1;
            end

            if (clr) begin
                xmin_q <= hit ? x_q : {X_W{1'b1}};
                xmax_q <= hit ? x_q : '0;
                ymin_q <= hit ? y_q : {Y_W{1'b1}};
                ymax_q <= hit ? y_q : '0;
            end else if (acc_en && hit) begin
                if (x_q < xmin_q) xmin_q <= x_q;
                if (x_q > xmax_q) xmax_q <= x_q;
                if (y_q < ymin_q) ymin_q <= y_q;
                if (y_q > ymax_q) ymax_q <= y_q;
            end

            // An empty frame leaves the trackers at their init values, so
            // publish zeros instead.
            if (publish) begin
                bxmin_q <= (acc_q == '0) ? '0 : xmin_q;
                bxmax_q <= (acc_q == '0) ? '0 : xmax_q;
                bymin_q <= (acc_q == '0) ? '0 : ymin_q;
                bymax_q <= (acc_q == '0) ? '0 : ymax_q;
            end
        end
    end

    assign bbox_xmin = bxmin_q;
    assign bbox_xmax = bxmax_q;
    assign bbox_ymin = bymin_q;
    assign bbox_ymax = bymax_q;
`else
    assign bbox_xmin = '0;
    assign bbox_xmax = '0;
    assign bbox_ymin = '0;
    assign bbox_ymax = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_motion_diff_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motion_diff_detect
//  Purpose  : Self-checking bench for motion_diff_detect. Random pixel data is
//             generated around a per-frame threshold; a frame-level model
//             (rectangle of motion pixels, counted by row/column index) gives
//             the expected statistics, and a per-cycle model of the 2-clk
//             pixel pipeline gives the expected mask and sync outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_motion_diff_detect;

    localparam int DATA_W     = 8;
    localparam int X_W        = 11;
    localparam int Y_W        = 11;
    localparam int CNT_W      = 21;
    localparam int MIN_PIXELS = 64;
`ifdef MOTION_BBOX_EN
    localparam bit BBOX = 1'b1;
`else
    localparam bit BBOX = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] data_cur = '0;
    logic [DATA_W-1:0] data_next = '0;
    logic [DATA_W-1:0] threshold = '0;
    logic              per_frame_vsync = 1'b0;
    logic              per_frame_href = 1'b0;
    logic              per_frame_clken = 1'b0;
    logic              post_frame_vsync, post_frame_href, post_frame_clken;
    logic [DATA_W-1:0] post_img_bit;
    logic [CNT_W-1:0]  motion_cnt;
    logic              motion_flag, frame_done;
    logic [X_W-1:0]    bbox_xmin, bbox_xmax;
    logic [Y_W-1:0]    bbox_ymin, bbox_ymax;

    always #5 clk = ~clk;

    motion_diff_detect #(
        .DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .MIN_PIXELS(MIN_PIXELS)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_cur         (data_cur),
        .data_next        (data_next),
        .threshold        (threshold),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_bit     (post_img_bit),
        .motion_cnt       (motion_cnt),
        .motion_flag      (motion_flag),
        .frame_done       (frame_done),
        .bbox_xmin        (bbox_xmin),
        .bbox_xmax        (bbox_xmax),
        .bbox_ymin        (bbox_ymin),
        .bbox_ymax        (bbox_ymax)
    );

    typedef struct {
        int cnt;
        int flag;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
    } fexp_t;

    int       n_checks = 0;
    int       n_errors = 0;
    fexp_t    exp_q[$];
    fexp_t    last_pub;
    logic [3:0] prev_e = '0;   // {vsync, href, clken, mask} of previous cycle's inputs
    logic     prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic ref_mask(input int c, input int n, input int t);
        int d;
        d = n - c;
        if (d < 0) d = -d;
        return (d > t);
    endfunction

    // One clock: remember what the pipeline must show one edge later, advance,
    // then compare against the inputs applied one call earlier.
    task automatic step();
        logic [3:0] cur_e;
        fexp_t      e;
        cur_e = {per_frame_vsync, per_frame_href, per_frame_clken,
                 ref_mask(int'(data_cur), int'(data_next), int'(threshold))};
        @(posedge clk);
        #1;
        check("pipe", 32'({post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit}),
              32'({prev_e[3:1], {DATA_W{prev_e[0]}}}));
        prev_e = cur_e;
        if (frame_done) begin
            check("done_single", 32'(prev_done), 32'd0);
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("motion_cnt", 32'(motion_cnt), e.cnt);
                check("motion_flag", 32'(motion_flag), e.flag);
                check("bbox_xmin", 32'(bbox_xmin), e.xmin);
                check("bbox_xmax", 32'(bbox_xmax), e.xmax);
                check("bbox_ymin", 32'(bbox_ymin), e.ymin);
                check("bbox_ymax", 32'(bbox_ymax), e.ymax);
                last_pub = e;
            end
        end
        prev_done = frame_done;
    endtask

    task automatic set_pix(input bit motion, input int thr);
        int diff, base;
        if (motion) diff = int'($urandom_range(255, thr + 1));
        else        diff = int'($urandom_range(thr, 0));
        base = int'($urandom_range(255 - diff, 0));
        if ($urandom_range(1, 0) == 1) begin
            data_cur  = DATA_W'(base);
            data_next = DATA_W'(base + diff);
        end else begin
            data_cur  = DATA_W'(base + diff);
            data_next = DATA_W'(base);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_vsync", 32'(post_frame_vsync), 32'd0);
        check("rst_href", 32'(post_frame_href), 32'd0);
        check("rst_clken", 32'(post_frame_clken), 32'd0);
        check("rst_img", 32'(post_img_bit), 32'd0);
        check("rst_cnt", 32'(motion_cnt), 32'd0);
        check("rst_flag", 32'(motion_flag), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_bbox", 32'(bbox_xmin | bbox_xmax | bbox_ymin | bbox_ymax), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        prev_e    = '0;
        prev_done = 1'b0;
        last_pub  = '{default: 0};
        exp_q.delete();
    endtask

    task automatic pix(input int c, input int n, input int t, input int exp);
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b1;
        data_cur  = DATA_W'(c);
        data_next = DATA_W'(n);
        threshold = DATA_W'(t);
        step();
        data_cur  = '0;
        data_next = '0;
        threshold = '0;
        step();
        check("pix_mask", 32'(post_img_bit), exp);
    endtask

    // Drive one frame whose motion pixels are the rectangle x0..x1, y0..y1.
    task automatic drive_frame(input int w, input int h, input int x0, input int x1,
                               input int y0, input int y1, input bit gaps,
                               input int vgap, input int rst_row);
        int    thr, cnt, xmn, xmx, ymn, ymx;
        bit    m, aborted;
        fexp_t e;
        thr = int'($urandom_range(200, 0));
        threshold = DATA_W'(thr);
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        repeat (vgap) begin set_pix(1'b1, thr); step(); end
        per_frame_vsync = 1'b1;
        repeat (3) begin
            per_frame_clken = 1'($urandom_range(1, 0));
            set_pix(1'b1, thr);
            step();
        end
        cnt = 0; xmn = 1 << 20; xmx = -1; ymn = 1 << 20; ymx = -1;
        aborted = 1'b0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r == rst_row && c == w / 2) begin
                    do_reset();
                    aborted = 1'b1;
                end
                if (gaps && $urandom_range(3, 0) == 0) begin
                    per_frame_href  = 1'b1;
                    per_frame_clken = 1'b0;
                    set_pix(1'b1, thr);
                    step();
                end
                m = (c >= x0) && (c <= x1) && (r >= y0) && (r <= y1);
                per_frame_href  = 1'b1;
                per_frame_clken = 1'b1;
                set_pix(m, thr);
                if (m) begin
                    cnt++;
                    if (c < xmn) xmn = c;
                    if (c > xmx) xmx = c;
                    if (r < ymn) ymn = r;
                    if (r > ymx) ymx = r;
                end
                step();
            end
            per_frame_href = 1'b0;
            repeat (3) begin
                per_frame_clken = 1'($urandom_range(1, 0));
                set_pix(1'b1, thr);
                step();
            end
        end
        per_frame_clken = 1'b0;
        repeat (2) begin set_pix(1'b1, thr); step(); end
        per_frame_vsync = 1'b0;
        if (!aborted) begin
            e.cnt  = cnt;
            e.flag = (cnt >= MIN_PIXELS) ? 1 : 0;
            if (!BBOX || cnt == 0) begin
                e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
            end else begin
                e.xmin = xmn; e.xmax = xmx; e.ymin = ymn; e.ymax = ymx;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_and_check(input int n);
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        repeat (n) begin
            per_frame_clken = 1'($urandom_range(1, 0));
            set_pix(1'($urandom_range(1, 0)), int'(threshold));
            step();
        end
        check("frames_pending", 32'(exp_q.size()), 32'd0);
        check("cnt_hold", 32'(motion_cnt), last_pub.cnt);
        check("flag_hold", 32'(motion_flag), last_pub.flag);
    endtask

    initial begin
        int x0, x1, y0, y1;
        last_pub = '{default: 0};
        @(posedge clk);
        #1;
        do_reset();
        repeat (2) step();

        // Single-pixel threshold behaviour
        pix(100, 130, 29, 32'hFF);
        pix(100, 130, 30, 32'h00);
        pix(200, 10, 50, 32'hFF);
        pix(77, 77, 0, 32'h00);
        pix(10, 200, 189, 32'hFF);
        pix(10, 200, 190, 32'h00);
        pix(0, 255, 254, 32'hFF);

        // 10x10 block at x=100..109, y=50..59
        drive_frame(120, 64, 100, 109, 50, 59, 1'b0, 4, -1);
        idle_and_check(10);

        // 63 pixels then 64 pixels, second frame starts right on the publish cycle
        drive_frame(32, 16, 3, 11, 2, 8, 1'b1, 4, -1);
        drive_frame(32, 16, 20, 27, 5, 12, 1'b1, 1, -1);
        idle_and_check(10);

        // Empty frame with clken gaps and blanking carrying motion data
        drive_frame(32, 16, 5, 4, 0, 15, 1'b1, 4, -1);
        idle_and_check(10);

        // Random rectangles
        for (int k = 0; k < 4; k++) begin
            x0 = int'($urandom_range(23, 0));
            x1 = int'($urandom_range(23, x0));
            y0 = int'($urandom_range(11, 0));
            y1 = int'($urandom_range(11, y0));
            drive_frame(24, 12, x0, x1, y0, y1, 1'b1, 3, -1);
        end
        idle_and_check(10);

        // Reset in the middle of a frame; the remainder must not publish
        drive_frame(32, 16, 0, 31, 0, 15, 1'b0, 4, 8);
        idle_and_check(10);
        drive_frame(32, 16, 4, 13, 6, 12, 1'b1, 4, -1);
        idle_and_check(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/motion_diff_detect.md
Name: motion_diff_detect

Overview:
- Parametrised frame-difference motion detector that sits between the frame-buffer read path (current/next frame pixel streams) and the display/overlay stage.
- Per pixel: registered absolute difference, strict threshold compare, binary mask output with the sync signals delayed to match.
- Per frame: counts motion pixels and locates them with a bounding box. Publishes frame statistics plus a motion flag at end of frame for the alarm/overlay logic.

Parameters:
- DATA_W, 8, pixel/threshold width in bits
- X_W, 11, column counter width (supports lines up to 2047 pixels)
- Y_W, 11, row counter width
- CNT_W, 21, motion-pixel counter width; counter saturates at 2^CNT_W-1
- MIN_PIXELS, 64, motion_flag asserted when frame motion count >= MIN_PIXELS

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- data_cur  in  DATA_W  current-frame pixel
- data_next  in  DATA_W  next-frame pixel
- threshold  in  DATA_W  difference threshold; sampled every cycle
- per_frame_vsync  in  1  frame valid, high for the whole frame
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel valid
- post_frame_vsync  out  1  vsync delayed 2 cycles
- post_frame_href  out  1  href delayed 2 cycles
- post_frame_clken  out  1  clken delayed 2 cycles
- post_img_bit  out  DATA_W  mask: all-ones = motion, 0 = static
- motion_cnt  out  CNT_W  motion pixels in last completed frame
- motion_flag  out  1  motion_cnt >= MIN_PIXELS for last completed frame
- frame_done  out  1  one-cycle pulse when statistics are updated
- bbox_xmin, bbox_xmax  out  X_W  bounding box columns (feature only)
- bbox_ymin, bbox_ymax  out  Y_W  bounding box rows (feature only)

Behaviour:
- Reset: the sync pipeline, post_img_bit, motion_cnt, motion_flag, frame_done and the internal counters are all 0. Bbox outputs reset to 0.
- Stage 1 (registered): diff = |data_next - data_cur|, computed at full DATA_W with no wrap. Equal inputs give 0.
- Stage 2 (registered): mask = (diff > threshold), strictly greater. threshold is captured in stage 1 so it is compared against the same pixel's diff. post_img_bit is {DATA_W{mask}}.
- Total latency is exactly 2 clk from input to post_* and post_img_bit. The sync signals pass through a 2-deep shift register. The mask is computed every cycle regardless of clken.
- Statistics operate on the stage-2 (post_*) signals only.
- Coordinates:
  - x is held at 0 while post href is low, and increments after each post clken with href high.
  - y is held at 0 while post vsync is low, and increments on each falling edge of post href.
  - Both saturate at all-ones and never wrap.
- Pixel qualifier: post_frame_vsync & post_frame_href & post_frame_clken.
- The accumulating counter increments on each qualified pixel whose mask is 1. It saturates at 2^CNT_W-1.
- Frame FSM states:
  - IDLE: wait for post vsync rising edge; on it, clear the accumulators and go to ACTIVE.
  - ACTIVE: accumulate; on post vsync falling edge go to PUBLISH.
  - PUBLISH: one cycle. Copy the accumulators to the outputs, set motion_flag, pulse frame_done=1, then return to IDLE.
- Outputs hold their values until the next PUBLISH.
- Simultaneous events:
  - A vsync rise during PUBLISH is honoured next cycle. The rise is latched in a pending bit and acted on in IDLE, so no frame is lost.
  - Motion on the last pixel of the frame is counted. Its increment lands before PUBLISH because the falling-edge detect lags by 1 cycle.
- Reset asserted mid-frame returns everything to reset values. The first frame after reset is only counted if its vsync rising edge occurs after reset release. A frame already in progress at release stays in IDLE.
- Frame with zero motion pixels: motion_cnt=0, motion_flag=0, bbox outputs = 0.

Optional Feature:
- Macro: MOTION_BBOX_EN.
- Defined:
  - On each qualified motion pixel, xmin/ymin track the minimum and xmax/ymax track the maximum of x and y.
  - The trackers are initialised in IDLE-to-ACTIVE to xmin/ymin = all-ones and xmax/ymax = 0.
  - They are published in PUBLISH. If the count is 0, all four bbox outputs are published as 0.
- Not defined: no bbox registers or comparators are built, and the bbox outputs are tied to 0. All other behaviour is unchanged.

Test Plan:
- data_cur=100, data_next=130, threshold=29 on one pixel -> post_img_bit=8'hFF exactly 2 clk later. With threshold=30 -> 8'h00.
- data_cur=200, data_next=10, threshold=50 -> 8'hFF, so no wrap error. Equal inputs 77/77 with threshold=0 -> 8'h00.
- 640x480 frame with a 10x10 motion block at x=100..109, y=50..59 -> motion_cnt=100, motion_flag=1, frame_done is a single pulse after the vsync fall. With MOTION_BBOX_EN: bbox = (100,109,50,59).
- Frame with 63 motion pixels and MIN_PIXELS=64 -> motion_flag=0. The next frame with 64 pixels -> motion_flag=1.
- Motion pixels with clken=0 or href=0 -> not counted. A frame with no motion -> motion_cnt=0 and bbox all 0.
- rst_n pulsed low mid-frame -> all outputs 0 within the reset. The partial frame is not published, and the next full frame publishes correct counts.
